multi_seq_detector: RTL and testbench
=====================================

Name: multi_seq_detector

Overview:
- Parametrised serial bit-pattern detector: the successor of the team's fixed 3-pattern Moore detector.
- Detects up to NUM_PAT runtime-programmable patterns, each up to MAX_LEN bits, on a qualified serial input stream.
- Overlapping and non-overlapping modes; priority-encoded match code; per-pattern saturating match counters.
- Sits between a serial bit source (deserialiser/UART front end) and control/status logic.

Parameters:
NUM_PAT, 4, number of independent pattern slots
MAX_LEN, 8, maximum pattern length in bits
CNT_W, 8, width of each per-pattern match counter
Derived: IDX_W = clog2(NUM_PAT); LEN_W = clog2(MAX_LEN+1); CODE_W = clog2(NUM_PAT+1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
x  in  1  serial data bit
x_valid  in  1  x is accepted this cycle when high
overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping
cfg_we  in  1  configuration write strobe
cfg_idx  in  IDX_W  slot being written
cfg_pattern  in  MAX_LEN  pattern; bit k = bit received k accepted bits before the newest
cfg_len  in  LEN_W  pattern length
cfg_en  in  1  slot enable
cfg_err  out  1  one-cycle pulse: rejected config write
cnt_clr  in  1  clear all match counters
cnt_sel  in  IDX_W  counter read select
cnt_out  out  CNT_W  counter[cnt_sel], combinational read
hit_vec  out  NUM_PAT  per-slot match flags for the last accepted bit
y  out  CODE_W  0 = no match, else 1 + lowest matching slot index

Behaviour:
- Reset (rst=1 at edge):
  - history and fill cleared; all slots disabled, pattern and length zeroed.
  - Counters cleared; y=0, hit_vec=0, cfg_err=0.
  - rst wins over every other input in the same cycle.
- History: MAX_LEN-bit shift register. On each accepted bit: history <= {history[MAX_LEN-2:0], x}.
- fill counts accepted bits since reset or last non-overlap match; saturates at MAX_LEN.
- Match for slot i on an accepted bit, evaluated on the updated history and fill: enabled_i AND fill >= len_i AND history[len_i-1:0] == pattern_i[len_i-1:0].
- Moore-style, 1-cycle latency: hit_vec and y register the result at the edge after the accepting cycle.
  - They hold until the next accepted bit; with x_valid=0 they do not change.
- Priority: y encodes the lowest-index matching slot; hit_vec reports all matching slots.
- Overlap mode: history and fill are unaffected by a match.
- Non-overlap mode:
  - If any slot matches, fill <= 0 on that edge; history contents are kept but not eligible.
  - The next match needs len fresh bits.
  - overlap_en is sampled per accepted bit.
- Config write (cfg_we=1):
  - Accepted iff 1 <= cfg_len <= MAX_LEN and cfg_idx < NUM_PAT; loads pattern, length and enable of the slot, and clears that slot's counter.
  - Otherwise rejected: no state change, cfg_err=1 for the next cycle.
  - Simultaneous with an accepted bit: that bit is evaluated with the old config; the new config applies from the next accepted bit.
- Counters:
  - counter_i increments on each slot-i match and saturates at 2^CNT_W-1.
  - cnt_clr in the same cycle as a match: clear wins, counter = 0.
  - Config clear of slot i has the same precedence over a match.
- cnt_sel >= NUM_PAT reads 0.

Decomposition:
- Shared package multi_seq_detector_pkg holds: default NUM_PAT/MAX_LEN/CNT_W, the code value NO_MATCH=0, and the slot config struct {pattern, len, en}.
- One natural sub-module: seq_slot_match (per-slot config registers, masked compare, saturating counter), instantiated NUM_PAT times via generate.
- Top level holds the history, fill, priority encoder and error logic.

Test Plan:
- Overlap: slot0 = 3'b101 len3 enabled, overlap_en=1, stream 1,0,1,0,1 -> y=1 one cycle after 3rd and 5th bits (else 0); cnt_out(sel0)=2.
- Non-overlap: same config, overlap_en=0, same stream -> y=1 only after 3rd bit; cnt=1; stream continues 0,1 -> match after 7th bit.
- Priority: slot0 = 2'b01 len2, slot1 = 3'b101 len3, stream 1,0,1 -> hit_vec=4'b0011, y=1; disable slot0, repeat after rst and reprogram -> y=2.
- Gaps and hold: 1,0,1 with two x_valid=0 cycles between bits -> y=1 only after last valid bit, stays 1 through idle cycles, returns 0 on next non-matching bit.
- Reset mid-stream: slot0=101; bits 1,0, then rst, then reprogram slot0, bit 1 -> no match (fill=1); y=0, hit_vec=0, all counters 0 after rst.
- Saturation and errors: CNT_W=2, pattern 1'b1 len1, six 1s -> cnt=3; cnt_clr on a matching cycle -> cnt=0; cfg_len=0 or cfg_len=9 with MAX_LEN=8 -> cfg_err=1 for one cycle, slot unchanged.

Source files
------------

// File: rtl/multi_seq_detector_pkg.sv
// Shared constants and types for the multi-pattern serial detector.
package multi_seq_detector_pkg;

  localparam int DEF_NUM_PAT = 4;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN + 1);

  // Match code reported on y when no enabled slot matched.
  localparam int NO_MATCH = 0;

  // One slot's programmed configuration at the default geometry.
  typedef struct packed {
    logic [DEF_MAX_LEN-1:0] pattern;
    logic [DEF_LEN_W-1:0]   len;
    logic                   en;
  } slot_cfg_t;

endpackage

// File: rtl/multi_seq_detector_slot.sv
// One pattern slot: config registers, masked compare against the updated
// history, and a saturating match counter.
module seq_slot_match #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               acc,
  input  logic [MAX_LEN-1:0] hist_next,
  input  logic [LEN_W-1:0]   fill_next,
  input  logic               cfg_wr,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_en,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   count
);

  // Same layout as the package slot type, sized to this instance.
  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               en;
  } cfg_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cfg_t               cfg_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [MAX_LEN-1:0] mask;

  // Configuration register: loaded only by an accepted write to this slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_reg <= '0;
    end else if (cfg_wr) begin
      cfg_reg <= '{pattern: cfg_pattern, len: cfg_len, en: cfg_en};
    end
  end

  // Compare mask: only the len newest history bits take part.
  always_comb begin
    mask = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      mask[k] = (k < int'(cfg_reg.len));
    end
  end

  assign match = cfg_reg.en && (fill_next >= cfg_reg.len) &&
                 (((hist_next ^ cfg_reg.pattern) & mask) == '0);

  // Saturating counter; any clear (global or reconfigure) beats a match.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (cfg_wr || cnt_clr) begin
      count_reg <= '0;
    end else if (acc && match && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/multi_seq_detector.sv
// Multi-pattern serial detector: shared history/fill, per-slot matchers,
// priority-encoded match code and config-write validation.
module multi_seq_detector
  import multi_seq_detector_pkg::*;
#(
  parameter int NUM_PAT = DEF_NUM_PAT,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  localparam int IDX_W  = $clog2(NUM_PAT),
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int CODE_W = $clog2(NUM_PAT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_valid,
  input  logic               overlap_en,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_en,
  output logic               cfg_err,
  input  logic               cnt_clr,
  input  logic [IDX_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]   cnt_out,
  output logic [NUM_PAT-1:0] hit_vec,
  output logic [CODE_W-1:0]  y
);

  // The newest bit always comes straight from x, so only the older
  // MAX_LEN-1 bits need to be stored.
  logic [MAX_LEN-2:0] history_reg;
  logic [LEN_W-1:0]   fill_reg;
  logic [NUM_PAT-1:0] hit_vec_reg;
  logic [CODE_W-1:0]  y_reg;
  logic               cfg_err_reg;

  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [NUM_PAT-1:0] match_vec;
  logic [CODE_W-1:0]  y_next;
  logic               cfg_valid;
  logic               cfg_ok;
  logic [CNT_W-1:0]   count_arr [NUM_PAT];

  assign hist_next = {history_reg, x};
  assign fill_next = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + 1'b1;

  assign cfg_valid = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN) &&
                     (32'(cfg_idx) < NUM_PAT);
  assign cfg_ok    = cfg_we && cfg_valid;

  for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_slot
    seq_slot_match #(
      .MAX_LEN(MAX_LEN),
      .CNT_W  (CNT_W),
      .LEN_W  (LEN_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .acc        (x_valid),
      .hist_next  (hist_next),
      .fill_next  (fill_next),
      .cfg_wr     (cfg_ok && (32'(cfg_idx) == gi)),
      .cfg_pattern(cfg_pattern),
      .cfg_len    (cfg_len),
      .cfg_en     (cfg_en),
      .cnt_clr    (cnt_clr),
      .match      (match_vec[gi]),
      .count      (count_arr[gi])
    );
  end

  // Priority encoder: the lowest-index matching slot wins the code.
  always_comb begin
    y_next = CODE_W'(NO_MATCH);
    for (int i = NUM_PAT - 1; i >= 0; i--) begin
      if (match_vec[i]) y_next = CODE_W'(i + 1);
    end
  end

  // Stream state and registered (Moore) outputs, updated per accepted bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      history_reg <= '0;
      fill_reg    <= '0;
      hit_vec_reg <= '0;
      y_reg       <= CODE_W'(NO_MATCH);
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_we && !cfg_valid;
      if (x_valid) begin
        history_reg <= hist_next[MAX_LEN-2:0];
        // Non-overlap: a match makes all stored bits ineligible.
        fill_reg    <= (!overlap_en && (|match_vec)) ? '0 : fill_next;
        hit_vec_reg <= match_vec;
        y_reg       <= y_next;
      end
    end
  end

  // Counter read port; out-of-range selects read as zero.
  always_comb begin
    cnt_out = '0;
    if (32'(cnt_sel) < NUM_PAT) cnt_out = count_arr[cnt_sel];
  end

  assign hit_vec = hit_vec_reg;
  assign y       = y_reg;
  assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_multi_seq_detector.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// against a queue-based model of the detection rules.
module tb_multi_seq_detector;
  import multi_seq_detector_pkg::*;

  localparam int NP = 4;
  localparam int ML = 8;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst, x, x_valid, overlap_en, cfg_we, cfg_en, cnt_clr;
  logic [1:0] cfg_idx, cnt_sel;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_err;
  logic [CW-1:0] cnt_out;
  logic [3:0] hit_vec;
  logic [2:0] y;

  multi_seq_detector #(.NUM_PAT(NP), .MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_en(cfg_en), .cfg_err(cfg_err),
    .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_out(cnt_out),
    .hit_vec(hit_vec), .y(y)
  );

  always #5 clk = ~clk;

  // Model state: eligible received bits (oldest first), slot configs, counts.
  slot_cfg_t m_cfg [NP];
  int        m_cnt [NP];
  bit        m_q [$];
  logic [3:0] m_hit;
  logic [2:0] m_y;
  logic      m_err;

  int n_chk  = 0;
  int n_fail = 0;
  bit ovl    = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the detection rules to the inputs present at this clock edge.
  task automatic model_edge();
    bit hit;
    bit any;
    int len;
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < NP; i++) begin
        m_cfg[i] = '0;
        m_cnt[i] = 0;
      end
      m_hit = '0; m_y = '0; m_err = 1'b0;
      return;
    end
    m_err = cfg_we && !(cfg_len >= 1 && cfg_len <= ML && int'(cfg_idx) < NP);
    if (x_valid) begin
      m_q.push_back(x);
      if (m_q.size() > ML) void'(m_q.pop_front());
      any = 1'b0; m_hit = '0; m_y = '0;
      for (int i = 0; i < NP; i++) begin
        len = int'(m_cfg[i].len);
        hit = m_cfg[i].en && (m_q.size() >= len);
        for (int k = 0; k < len && hit; k++)
          if (m_q[m_q.size() - 1 - k] != m_cfg[i].pattern[k]) hit = 1'b0;
        if (hit) begin
          m_hit[i] = 1'b1;
          if (!any) m_y = 3'(i + 1);
          any = 1'b1;
          if (m_cnt[i] < CMAX) m_cnt[i]++;
        end
      end
      if (!overlap_en && any) m_q.delete();
    end
    if (cnt_clr) for (int i = 0; i < NP; i++) m_cnt[i] = 0;
    if (cfg_we && !m_err) begin
      m_cfg[cfg_idx] = '{pattern: cfg_pattern, len: cfg_len, en: cfg_en};
      m_cnt[cfg_idx] = 0;
    end
  endtask

  task automatic step(input bit r, input bit xb, input bit xv, input bit ov,
                      input bit we, input logic [1:0] idx, input logic [7:0] pat,
                      input logic [3:0] len, input bit en, input bit clr);
    rst = r; x = xb; x_valid = xv; overlap_en = ov; cfg_we = we;
    cfg_idx = idx; cfg_pattern = pat; cfg_len = len; cfg_en = en; cnt_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    chk("y", 32'(y), 32'(m_y));
    chk("hit_vec", 32'(hit_vec), 32'(m_hit));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    for (int s = 0; s < NP; s++) begin
      cnt_sel = 2'(s);
      #1;
      chk($sformatf("cnt%0d", s), 32'(cnt_out), 32'(m_cnt[s]));
    end
  endtask

  task automatic bitv(input bit xb);
    step(0, xb, 1, ovl, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic idle();
    step(0, 0, 0, ovl, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic cfg(input logic [1:0] idx, input logic [7:0] pat, input logic [3:0] len, input bit en);
    step(0, 0, 0, ovl, 1, idx, pat, len, en, 0);
  endtask
  task automatic do_rst();
    step(1, 0, 0, ovl, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic read_cnt(input int s, input int exp, input string tag);
    cnt_sel = 2'(s);
    #1;
    chk(tag, 32'(cnt_out), 32'(exp));
  endtask

  initial begin
    rst = 1; x = 0; x_valid = 0; overlap_en = 1; cfg_we = 0; cfg_idx = 0;
    cfg_pattern = 0; cfg_len = 0; cfg_en = 0; cnt_clr = 0; cnt_sel = 0;

    // Reset state.
    do_rst(); do_rst();
    chk("rst_y", 32'(y), 0);
    chk("rst_hit", 32'(hit_vec), 0);

    // Overlapping detection of 101 in 1,0,1,0,1.
    ovl = 1;
    cfg(0, 8'b101, 3, 1);
    bitv(1); bitv(0); bitv(1);
    chk("ovl_y3", 32'(y), 1);
    bitv(0); bitv(1);
    chk("ovl_y5", 32'(y), 1);
    read_cnt(0, 2, "ovl_cnt");

    // Non-overlapping detection of the same stream.
    do_rst(); ovl = 0;
    cfg(0, 8'b101, 3, 1);
    bitv(1); bitv(0); bitv(1); bitv(0); bitv(1);
    chk("novl_y5", 32'(y), 0);
    read_cnt(0, 1, "novl_cnt1");
    bitv(0); bitv(1);
    chk("novl_y7", 32'(y), 1);
    read_cnt(0, 2, "novl_cnt2");

    // Priority between two simultaneous matches.
    do_rst(); ovl = 1;
    cfg(0, 8'b01, 2, 1); cfg(1, 8'b101, 3, 1);
    bitv(1); bitv(0); bitv(1);
    chk("pri_hit", 32'(hit_vec), 32'h3);
    chk("pri_y", 32'(y), 1);
    do_rst();
    cfg(0, 8'b01, 2, 0); cfg(1, 8'b101, 3, 1);
    bitv(1); bitv(0); bitv(1);
    chk("pri_y2", 32'(y), 2);

    // Gaps between valid bits; output holds through idle cycles.
    do_rst();
    cfg(0, 8'b101, 3, 1);
    bitv(1); idle(); idle(); bitv(0); idle(); idle(); bitv(1);
    chk("gap_y", 32'(y), 1);
    idle(); idle();
    chk("gap_hold", 32'(y), 1);
    bitv(0);
    chk("gap_drop", 32'(y), 0);

    // Reset mid-stream discards history.
    do_rst();
    cfg(0, 8'b101, 3, 1);
    bitv(1); bitv(0);
    do_rst();
    cfg(0, 8'b101, 3, 1);
    bitv(1);
    chk("midrst_y", 32'(y), 0);

    // Counter saturation, clear precedence, rejected config writes.
    do_rst();
    cfg(2, 8'b1, 1, 1);
    for (int i = 0; i < 6; i++) bitv(1);
    read_cnt(2, 3, "sat_cnt");
    step(0, 1, 1, ovl, 0, 0, 0, 0, 0, 1);
    chk("clr_y", 32'(y), 3);
    read_cnt(2, 0, "clr_cnt");
    cfg(2, 8'h00, 0, 1);
    chk("err_len0", 32'(cfg_err), 1);
    bitv(1);
    chk("err_pulse", 32'(cfg_err), 0);
    chk("err_keep", 32'(y), 3);
    cfg(2, 8'h00, 9, 1);
    chk("err_len9", 32'(cfg_err), 1);
    bitv(1);
    chk("err_keep9", 32'(y), 3);

    // Random traffic against the model.
    do_rst();
    for (int n = 0; n < 1500; n++) begin
      bit r, we, clr;
      if ($urandom_range(0, 9) == 0) ovl = ~ovl;
      r   = ($urandom_range(0, 99) == 0);
      we  = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 29) == 0);
      step(r, 1'($urandom), ($urandom_range(0, 3) != 0), ovl, we,
           2'($urandom), 8'($urandom),
           ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(1, 4)),
           ($urandom_range(0, 4) != 0), clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
